// File: rtl/key_event_pkg.sv
// Shared types and byte codes for the keyboard event path.
// Build option: KEY_EVENT_FIFO_BACKSPACE_EN turns KEY_BACKSPACE into an edit command.
package key_event_pkg;

    // The debouncer produces bytes of this type.
    typedef logic [7:0] keyByte_t;

    localparam keyByte_t KEY_RELEASE   = 8'h00;
    localparam keyByte_t KEY_BACKSPACE = 8'h08;

    localparam int KEY_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/key_fifo_mem.sv
// DEPTH x 8 storage for the key event FIFO.
// It has one synchronous write port and one asynchronous read port.
// The array is not reset, so an entry holds no meaningful value until it is written.
module key_fifo_mem
    import key_event_pkg::*;
#(
    parameter  int DEPTH = KEY_FIFO_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  keyByte_t         wdata,
    input  logic [PTR_W-1:0] raddr,
    output keyByte_t         rdata
);

    keyByte_t mem_q [DEPTH];

    // Write the incoming byte into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/key_event_fifo.sv
// Buffers debounced key presses in a circular FIFO for the game/text logic.
// Release codes are dropped. A press that arrives while the FIFO is full sets a sticky overflow flag.
// Build option: KEY_EVENT_FIFO_BACKSPACE_EN makes KEY_BACKSPACE retract the newest unread entry.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter  int DEPTH = KEY_FIFO_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           RST,
    input  keyByte_t       keyByte,
    input  logic           keyReady,
    output keyByte_t       rdata,
    output logic           rvalid,
    input  logic           rready,
    output logic [PTR_W:0] count,
    output logic           overflow,
    input  logic           overflowClr
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic push_req, edit_req, pop, full, do_push, do_edit, drop;

    // Classify the incoming strobe and work out the next pointer, count and flag values.
    // Fullness comes from the count, because the pointers alone cannot tell full from empty.
    always_comb begin
        push_req = keyReady && (keyByte != KEY_RELEASE);
        edit_req = 1'b0;
`ifdef KEY_EVENT_FIFO_BACKSPACE_EN
        if (keyByte == KEY_BACKSPACE) begin
            push_req = 1'b0;
            edit_req = keyReady;
        end
`endif
        pop     = (count_q != '0) && rready;
        full    = (count_q == CNT_W'(DEPTH));
        do_push = push_req && (!full || pop);
        drop    = push_req && full && !pop;
        // When a pop takes the last entry, no entry is left for the edit to retract.
        do_edit = edit_req && (pop ? (count_q >= CNT_W'(2)) : (count_q != '0));

        wptr_d = wptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else if (do_edit) begin
            wptr_d = wptr_q - PTR_W'(1);
        end

        rptr_d = pop ? (rptr_q + PTR_W'(1)) : rptr_q;

        count_d = count_q;
        if (do_push) count_d = count_d + CNT_W'(1);
        if (pop)     count_d = count_d - CNT_W'(1);
        if (do_edit) count_d = count_d - CNT_W'(1);

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflowClr) begin
            overflow_d = 1'b0;
        end
    end

    // Register the pointers, the occupancy and the sticky flag. Reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    key_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wptr_q),
        .wdata (keyByte),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    assign rvalid   = (count_q != '0);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
